// File: rtl/r0_seq.sv
// R0 flag-update sequencer: arbitrates load/compare/ALU/shift requests and
// emits registered load, L/E/G capture and flag strobe sequences to R0.
module r0_seq (
    input  logic       clk_sys,
    input  logic       zer_,
    input  logic       req_ld,
    input  logic       req_cmp,
    input  logic       req_alu,
    input  logic       req_shf,
    input  logic [0:3] ld_sel,
    input  logic [0:2] alu_mask,
    input  logic [0:1] shf_mask,
    output logic       ack_ld,
    output logic       ack_cmp,
    output logic       ack_alu,
    output logic       ack_shf,
    output logic       strob1,
    output logic       ust_z,
    output logic       ust_mc,
    output logic       ust_v,
    output logic       ust_y,
    output logic       ust_x,
    output logic       cleg_,
    output logic       w_zmvc,
    output logic       w_legy,
    output logic       w8_x,
    output logic       lrp,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StStrobe, StHold} state_e;
    typedef enum logic [1:0] {GntLd, GntCmp, GntAlu, GntShf} grant_e;

    state_e     state_q, state_d;
    grant_e     grant_q, grant_d;
    logic [0:3] ld_q, ld_d;
    logic [4:0] ust_q, ust_d;  // {z, mc, v, y, x}
    logic [1:0] starve_q, starve_d;

    logic       strobing;
    logic       strob1_d, cleg_d, busy_d;
    logic [4:0] ust_out_d;
    logic [0:3] w_d;
    logic [3:0] ack_d;  // {ld, cmp, alu, shf}

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ld_d     = ld_q;
        ust_d    = ust_q;
        starve_d = starve_q;

        unique case (state_q)
            StIdle: begin
                if (req_ld || req_cmp || req_alu || req_shf) begin
                    // A starved shift outranks cmp/alu, never a load.
                    if (req_ld)                             grant_d = GntLd;
                    else if (req_shf && starve_q == 2'd3)   grant_d = GntShf;
                    else if (req_cmp)                       grant_d = GntCmp;
                    else if (req_alu)                       grant_d = GntAlu;
                    else                                    grant_d = GntShf;

                    if (grant_d == GntShf)                  starve_d = 2'd0;
                    else if (req_shf && starve_q != 2'd3)   starve_d = starve_q + 2'd1;

                    unique case (grant_d)
                        GntLd: begin
                            ld_d    = ld_sel;
                            state_d = (ld_sel == 4'b0000) ? StHold : StLoad;
                        end
                        GntCmp: begin
                            ust_d   = 5'b00000;
                            state_d = StSetup;
                        end
                        GntAlu: begin
                            ust_d   = {alu_mask[0], alu_mask[1], alu_mask[2], 2'b00};
                            state_d = (alu_mask == 3'b000) ? StHold : StSetup;
                        end
                        GntShf: begin
                            ust_d   = {3'b000, shf_mask[0], shf_mask[1]};
                            state_d = (shf_mask == 2'b00) ? StHold : StSetup;
                        end
                    endcase
                end
            end
            StLoad:   state_d = StHold;
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = StHold;
            StHold:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        strobing  = ((grant_d == GntAlu) || (grant_d == GntShf)) &&
                    ((state_d == StSetup) || (state_d == StStrobe));
        ust_out_d = strobing ? ust_d : 5'b00000;
        strob1_d  = strobing && (state_d == StStrobe);
        cleg_d    = !((grant_d == GntCmp) &&
                      ((state_d == StSetup) || (state_d == StStrobe)));
        w_d       = (state_d == StLoad) ? ld_d : 4'b0000;
        ack_d     = 4'b0000;
        if (state_d == StHold) begin
            ack_d[3] = (grant_d == GntLd);
            ack_d[2] = (grant_d == GntCmp);
            ack_d[1] = (grant_d == GntAlu);
            ack_d[0] = (grant_d == GntShf);
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_sys or negedge zer_) begin
        if (!zer_) begin
            state_q  <= StIdle;
            grant_q  <= GntLd;
            ld_q     <= 4'b0000;
            ust_q    <= 5'b00000;
            starve_q <= 2'd0;
            strob1   <= 1'b0;
            {ust_z, ust_mc, ust_v, ust_y, ust_x} <= 5'b00000;
            cleg_    <= 1'b1;
            {w_zmvc, w_legy, w8_x, lrp}          <= 4'b0000;
            {ack_ld, ack_cmp, ack_alu, ack_shf}  <= 4'b0000;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ld_q     <= ld_d;
            ust_q    <= ust_d;
            starve_q <= starve_d;
            strob1   <= strob1_d;
            {ust_z, ust_mc, ust_v, ust_y, ust_x} <= ust_out_d;
            cleg_    <= cleg_d;
            {w_zmvc, w_legy, w8_x, lrp}          <= w_d;
            {ack_ld, ack_cmp, ack_alu, ack_shf}  <= ack_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_r0_seq.sv
// Directed bench for r0_seq: cycle-by-cycle output vectors checked against
// hand-computed values; outputs sampled on the falling clock edge.
module tb_r0_seq;

    logic       clk_sys = 1'b0;
    logic       zer_;
    logic       req_ld, req_cmp, req_alu, req_shf;
    logic [0:3] ld_sel;
    logic [0:2] alu_mask;
    logic [0:1] shf_mask;
    logic       ack_ld, ack_cmp, ack_alu, ack_shf;
    logic       strob1, ust_z, ust_mc, ust_v, ust_y, ust_x, cleg_;
    logic       w_zmvc, w_legy, w8_x, lrp, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    r0_seq dut (
        .clk_sys  (clk_sys),
        .zer_     (zer_),
        .req_ld   (req_ld),
        .req_cmp  (req_cmp),
        .req_alu  (req_alu),
        .req_shf  (req_shf),
        .ld_sel   (ld_sel),
        .alu_mask (alu_mask),
        .shf_mask (shf_mask),
        .ack_ld   (ack_ld),
        .ack_cmp  (ack_cmp),
        .ack_alu  (ack_alu),
        .ack_shf  (ack_shf),
        .strob1   (strob1),
        .ust_z    (ust_z),
        .ust_mc   (ust_mc),
        .ust_v    (ust_v),
        .ust_y    (ust_y),
        .ust_x    (ust_x),
        .cleg_    (cleg_),
        .w_zmvc   (w_zmvc),
        .w_legy   (w_legy),
        .w8_x     (w8_x),
        .lrp      (lrp),
        .busy     (busy)
    );

    // {strob1, ust_z, ust_mc, ust_v, ust_y, ust_x, cleg_, w_zmvc, w_legy, w8_x, lrp,
    //  ack_ld, ack_cmp, ack_alu, ack_shf, busy}
    logic [15:0] outs;
    assign outs = {strob1, ust_z, ust_mc, ust_v, ust_y, ust_x, cleg_,
                   w_zmvc, w_legy, w8_x, lrp, ack_ld, ack_cmp, ack_alu, ack_shf, busy};

    function automatic logic [15:0] ov(input logic s, input logic [4:0] u, input logic c,
                                       input logic [3:0] w, input logic [3:0] a,
                                       input logic b);
        return {s, u, c, w, a, b};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    localparam logic [15:0] Idle = 16'b0_00000_1_0000_0000_0;

    logic [3:0] ack_log[$];
    logic [3:0] exp_acks[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};

    initial begin
        zer_ = 1'b0;
        {req_ld, req_cmp, req_alu, req_shf} = 4'b0000;
        ld_sel = 4'b0000; alu_mask = 3'b000; shf_mask = 2'b00;
        repeat (2) @(negedge clk_sys);
        check("reset_state", outs, Idle);
        zer_ = 1'b1;
        cyc();
        check("idle_after_reset", outs, Idle);

        // ALU with mask Z,V; mask change after grant must be ignored.
        req_alu = 1'b1; alu_mask = 3'b101;
        cyc();
        check("alu_setup", outs, ov(1'b0, 5'b10100, 1'b1, 4'b0000, 4'b0000, 1'b1));
        alu_mask = 3'b010;
        cyc();
        check("alu_strobe", outs, ov(1'b1, 5'b10100, 1'b1, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("alu_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b0010, 1'b1));
        req_alu = 1'b0;
        cyc();
        check("alu_idle", outs, Idle);

        // Load ZMVC + R0[9:15].
        req_ld = 1'b1; ld_sel = 4'b1001;
        cyc();
        check("ld_load", outs, ov(1'b0, 5'b00000, 1'b1, 4'b1001, 4'b0000, 1'b1));
        cyc();
        check("ld_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b1000, 1'b1));
        req_ld = 1'b0;
        cyc();
        check("ld_idle", outs, Idle);

        // cmp and alu together: cmp first, alu ack 4 cycles after ack_cmp.
        req_cmp = 1'b1; req_alu = 1'b1; alu_mask = 3'b001;
        cyc();
        check("cmp_setup", outs, ov(1'b0, 5'b00000, 1'b0, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("cmp_strobe", outs, ov(1'b0, 5'b00000, 1'b0, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("cmp_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b0100, 1'b1));
        req_cmp = 1'b0;
        cyc();
        check("between_idle", outs, Idle);
        cyc();
        check("alu2_setup", outs, ov(1'b0, 5'b00100, 1'b1, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("alu2_strobe", outs, ov(1'b1, 5'b00100, 1'b1, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("alu2_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b0010, 1'b1));
        req_alu = 1'b0;
        cyc();
        check("alu2_idle", outs, Idle);

        // Starvation: shf wins after three cmp grants, then counter is back to 0.
        req_cmp = 1'b1; req_alu = 1'b1; req_shf = 1'b1; shf_mask = 2'b11;
        for (int i = 0; i < 60 && ack_log.size() < 5; i++) begin
            cyc();
            if ({ack_ld, ack_cmp, ack_alu, ack_shf} != 4'b0000)
                ack_log.push_back({ack_ld, ack_cmp, ack_alu, ack_shf});
        end
        {req_cmp, req_alu, req_shf} = 3'b000;
        check("starve_ack_count", 16'(ack_log.size()), 16'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("starve_ack%0d", i),
                  (i < ack_log.size()) ? {12'd0, ack_log[i]} : 16'hffff,
                  {12'd0, exp_acks[i]});
        repeat (6) cyc();
        check("starve_idle", outs, Idle);

        // Asynchronous reset during STROBE aborts; held req restarts at SETUP.
        req_alu = 1'b1; alu_mask = 3'b110;
        cyc();
        cyc();
        check("rst_pre_strobe", outs, ov(1'b1, 5'b11000, 1'b1, 4'b0000, 4'b0000, 1'b1));
        #2 zer_ = 1'b0;
        #1 check("rst_async", outs, Idle);
        @(negedge clk_sys);
        check("rst_held", outs, Idle);
        zer_ = 1'b1;
        cyc();
        check("rst_restart_setup", outs,
              ov(1'b0, 5'b11000, 1'b1, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("rst_restart_strobe", outs,
              ov(1'b1, 5'b11000, 1'b1, 4'b0000, 4'b0000, 1'b1));
        cyc();
        check("rst_restart_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b0010, 1'b1));
        req_alu = 1'b0;
        cyc();
        check("rst_restart_idle", outs, Idle);

        // Empty shift mask goes straight to HOLD.
        req_shf = 1'b1; shf_mask = 2'b00;
        cyc();
        check("shf_empty_ack", outs, ov(1'b0, 5'b00000, 1'b1, 4'b0000, 4'b0001, 1'b1));
        req_shf = 1'b0;
        cyc();
        check("shf_empty_idle", outs, Idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
